// File: rtl/button_pkg.sv
// Shared types and constants for the push-button conditioning blocks.
package button_pkg;

    localparam int unsigned CNT_W = 32;

    typedef logic [CNT_W-1:0] cnt_t;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    // The hold counter runs in both of these states, so a release bounce
    // does not restart the long-press timing.
    function automatic logic holding(input state_t s);
        return (s == PRESSED) || (s == RELEASE_WAIT);
    endfunction

endpackage

// File: rtl/button_sync.sv
// Two-flop synchroniser for an asynchronous pin, reset to a chosen idle value.
module button_sync #(
    parameter bit RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/button_debounce.sv
// Button synchroniser/debouncer with press, release and long-press pulses.
// Define BUTTON_AUTOREPEAT_EN for repeated press pulses while held; the
// release pulse port is release_pulse because release is a reserved word.
module button_debounce
    import button_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned LONG_CYCLES     = 50_000_000,
    parameter int unsigned REPEAT_CYCLES   = 10_000_000,
    parameter bit          ACTIVE_LOW      = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic btn_level,
    output logic press,
    output logic release_pulse,
    output logic long_press
);

    localparam cnt_t DB_LAST   = cnt_t'(DEBOUNCE_CYCLES - 1);
    localparam cnt_t LONG_LAST = cnt_t'(LONG_CYCLES - 1);
    localparam cnt_t LONG_MAX  = cnt_t'(LONG_CYCLES);

    logic   raw;
    logic   sample;
    state_t state, state_nxt;
    cnt_t   dcnt, dcnt_nxt;
    cnt_t   hcnt, hcnt_nxt;
    logic   level_nxt;
    logic   press_nxt;
    logic   release_nxt;
    logic   long_nxt;
    logic   rep_fire;

    // Normalised so the synchroniser always resets to "released" = 0.
    assign raw = btn_in ^ ACTIVE_LOW;

    button_sync #(
        .RST_VAL(1'b0)
    ) u_sync (
        .clk(clk),
        .rst(rst),
        .d  (raw),
        .q  (sample)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            dcnt          <= '0;
            hcnt          <= '0;
            btn_level     <= 1'b0;
            press         <= 1'b0;
            release_pulse <= 1'b0;
            long_press    <= 1'b0;
        end else begin
            state         <= state_nxt;
            dcnt          <= dcnt_nxt;
            hcnt          <= hcnt_nxt;
            btn_level     <= level_nxt;
            press         <= press_nxt | rep_fire;
            release_pulse <= release_nxt;
            long_press    <= long_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        dcnt_nxt  = dcnt;
        unique case (state)
            IDLE: begin
                if (sample) begin
                    state_nxt = PRESS_WAIT;
                    dcnt_nxt  = '0;
                end
            end
            PRESS_WAIT: begin
                if (!sample) begin
                    state_nxt = IDLE;
                    dcnt_nxt  = '0;
                end else if (dcnt == DB_LAST) begin
                    state_nxt = PRESSED;
                end else begin
                    dcnt_nxt = dcnt + 1'b1;
                end
            end
            PRESSED: begin
                if (!sample) begin
                    state_nxt = RELEASE_WAIT;
                    dcnt_nxt  = '0;
                end
            end
            RELEASE_WAIT: begin
                if (sample) begin
                    state_nxt = PRESSED;
                end else if (dcnt == DB_LAST) begin
                    state_nxt = IDLE;
                end else begin
                    dcnt_nxt = dcnt + 1'b1;
                end
            end
        endcase

        hcnt_nxt = hcnt;
        if (state == PRESS_WAIT && state_nxt == PRESSED) begin
            hcnt_nxt = '0;
        end else if (holding(state) && hcnt < LONG_MAX) begin
            hcnt_nxt = hcnt + 1'b1;
        end
    end

    always_comb begin
        press_nxt   = (state == PRESS_WAIT) && sample && (dcnt == DB_LAST);
        release_nxt = (state == RELEASE_WAIT) && !sample && (dcnt == DB_LAST);
        long_nxt    = holding(state) && (hcnt == LONG_LAST);
        level_nxt   = btn_level;
        if (press_nxt) begin
            level_nxt = 1'b1;
        end else if (release_nxt) begin
            level_nxt = 1'b0;
        end
    end

`ifdef BUTTON_AUTOREPEAT_EN
    localparam cnt_t REP_LAST = cnt_t'(REPEAT_CYCLES - 1);

    cnt_t rcnt, rcnt_nxt;

    // Runs only once the hold counter has saturated, i.e. after long_press.
    always_comb begin
        rcnt_nxt = '0;
        rep_fire = 1'b0;
        if (state == PRESSED && hcnt == LONG_MAX) begin
            if (rcnt == REP_LAST) begin
                rep_fire = 1'b1;
            end else begin
                rcnt_nxt = rcnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rcnt <= '0;
        end else begin
            rcnt <= rcnt_nxt;
        end
    end
`else
    logic unused_repeat;

    assign rep_fire      = 1'b0;
    assign unused_repeat = ^cnt_t'(REPEAT_CYCLES);
`endif

endmodule

// File: tb/tb_button_debounce.sv
// Scoreboard bench for button_debounce: one active-high and one active-low instance.
module tb_button_debounce;

    localparam int unsigned DB = 4;
    localparam int unsigned LG = 20;
    localparam int unsigned RP = 8;

    localparam int K_PRESS   = 0;
    localparam int K_RELEASE = 1;
    localparam int K_LONG    = 2;

    typedef struct {
        int          dut;
        int          kind;
        int unsigned cyc;
    } ev_t;

    logic clk     = 1'b0;
    logic rst     = 1'b0;
    logic btn     = 1'b0;
    logic btn_low = 1'b1;

    logic lvl0, p0, r0, l0;
    logic lvl1, p1, r1, l1;

    int unsigned cyc    = 0;
    int          checks = 0;
    int          errors = 0;
    ev_t         sbq[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    button_debounce #(
        .DEBOUNCE_CYCLES(DB),
        .LONG_CYCLES    (LG),
        .REPEAT_CYCLES  (RP),
        .ACTIVE_LOW     (1'b0)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .btn_in       (btn),
        .btn_level    (lvl0),
        .press        (p0),
        .release_pulse(r0),
        .long_press   (l0)
    );

    button_debounce #(
        .DEBOUNCE_CYCLES(DB),
        .LONG_CYCLES    (LG),
        .REPEAT_CYCLES  (RP),
        .ACTIVE_LOW     (1'b1)
    ) u_dut_low (
        .clk          (clk),
        .rst          (rst),
        .btn_in       (btn_low),
        .btn_level    (lvl1),
        .press        (p1),
        .release_pulse(r1),
        .long_press   (l1)
    );

    function automatic string kname(input int k);
        case (k)
            K_PRESS:   return "press";
            K_RELEASE: return "release";
            default:   return "long_press";
        endcase
    endfunction

    task automatic expect_ev(input int dut, input int kind, input int unsigned at);
        ev_t e;
        e.dut  = dut;
        e.kind = kind;
        e.cyc  = at;
        sbq.push_back(e);
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic check_vec(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Monitor: every observed pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        logic [2:0] obs [2];
        ev_t        e;
        obs[0] = {l0, r0, p0};
        obs[1] = {l1, r1, p1};
        while (sbq.size() > 0 && sbq[0].cyc < cyc) begin
            checks++;
            errors++;
            $display("FAIL missed_event: dut %0d %s expected at cycle %0d, not observed by cycle %0d",
                     sbq[0].dut, kname(sbq[0].kind), sbq[0].cyc, cyc);
            void'(sbq.pop_front());
        end
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 3; k++) begin
                if (obs[d][k]) begin
                    checks++;
                    if (sbq.size() > 0 && sbq[0].dut == d && sbq[0].kind == k && sbq[0].cyc == cyc) begin
                        void'(sbq.pop_front());
                    end else if (sbq.size() > 0 && sbq[0].cyc == cyc) begin
                        e = sbq.pop_front();
                        errors++;
                        $display("FAIL event_kind: got dut %0d %s at cycle %0d, expected dut %0d %s",
                                 d, kname(k), cyc, e.dut, kname(e.kind));
                    end else begin
                        errors++;
                        $display("FAIL unexpected_event: got dut %0d %s at cycle %0d, expected none",
                                 d, kname(k), cyc);
                    end
                end
            end
        end
    end

    initial begin
        int unsigned n;
        int unsigned p;

        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        check_vec("reset_outputs", {lvl0, p0, r0, l0, lvl1, p1, r1, l1}, 8'h00);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Clean press, a 3-cycle release glitch, then a release timed so the
        // release edge coincides with the 20th hold cycle.
        n = cyc;
        btn = 1'b1;
        p = n + 7;
        expect_ev(0, K_PRESS, p);
        repeat (9) @(negedge clk);
        check_bit("clean_press_level", lvl0, 1'b1);
        btn = 1'b0;
        repeat (3) @(negedge clk);
        btn = 1'b1;
        repeat (8) @(negedge clk);
        btn = 1'b0;
        expect_ev(0, K_RELEASE, p + 20);
        expect_ev(0, K_LONG, p + 20);
        repeat (6) @(negedge clk);
        check_bit("level_before_release", lvl0, 1'b1);
        repeat (2) @(negedge clk);
        check_bit("level_after_release", lvl0, 1'b0);

        // Bounce rejection.
        for (int i = 0; i < 4; i++) begin
            btn = (i % 2 == 0);
            repeat (2) @(negedge clk);
        end
        repeat (8) @(negedge clk);
        check_bit("bounce_level", lvl0, 1'b0);

        // Long hold.
        n = cyc;
        btn = 1'b1;
        p = n + 7;
        expect_ev(0, K_PRESS, p);
        expect_ev(0, K_LONG, p + 20);
`ifdef BUTTON_AUTOREPEAT_EN
        expect_ev(0, K_PRESS, p + 28);
        expect_ev(0, K_PRESS, p + 36);
`endif
        repeat (45) @(negedge clk);
        check_bit("hold_level", lvl0, 1'b1);

        // Reset while held.
        #2 rst = 1'b1;
        #1 check_vec("reset_mid_hold", {lvl0, p0, r0, l0, lvl1, p1, r1, l1}, 8'h00);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        n = cyc;
        expect_ev(0, K_PRESS, n + 7);
        repeat (10) @(negedge clk);
        check_bit("repress_level", lvl0, 1'b1);
        btn = 1'b0;
        expect_ev(0, K_RELEASE, n + 17);
        repeat (10) @(negedge clk);
        check_bit("rerelease_level", lvl0, 1'b0);

        // Active-low instance.
        n = cyc;
        btn_low = 1'b0;
        expect_ev(1, K_PRESS, n + 7);
        repeat (10) @(negedge clk);
        check_bit("low_press_level", lvl1, 1'b1);
        n = cyc;
        btn_low = 1'b1;
        expect_ev(1, K_RELEASE, n + 7);
        repeat (10) @(negedge clk);
        check_bit("low_release_level", lvl1, 1'b0);

        repeat (5) @(negedge clk);
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL pending_events: got %0d outstanding expected 0", sbq.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
